// File: rtl/ex_muldiv.sv
// ex_muldiv: RV32M EX-stage unit with a registered 2-cycle multiply and an iterative restoring divide.
// Holds the pipeline while busy, then presents one writeback beat to the EX result mux.
module ex_muldiv #(
    parameter int XLEN = 32
) (
    input  logic            clk_100MHz,
    input  logic            arst_n,
    input  logic [31:0]     inst_i,
    input  logic [XLEN-1:0] reg1_r_data_i,
    input  logic [XLEN-1:0] reg2_r_data_i,
    input  logic [4:0]      reg_w_addr_i,
    input  logic            jump_ena_i,
    output logic            hold_req_o,
    output logic            busy_o,
    output logic            wb_valid_o,
    output logic            reg_w_e_o,
    output logic [4:0]      reg_w_addr_o,
    output logic [XLEN-1:0] result_o
);
    localparam int CW = $clog2(XLEN);

    typedef enum logic [1:0] {IDLE, DIV_BUSY, DONE} state_t;

    state_t          r_state;
    logic [CW-1:0]   r_cnt;
    logic [4:0]      r_rd;
    logic            r_rem_sel;
    logic            r_neg_q;
    logic            r_neg_r;
    logic [XLEN-1:0] r_quot;
    logic [XLEN-1:0] r_rem;
    logic [XLEN-1:0] r_divisor;
    logic [XLEN-1:0] r_result;

    logic              w_go;
    logic              w_sgn;
    logic              w_ovf;
    logic              w_wb;
    logic              w_unused;
    logic [2:0]        w_f3;
    logic [2*XLEN-1:0] w_ma;
    logic [2*XLEN-1:0] w_mb;
    logic [2*XLEN-1:0] w_prod;
    logic [XLEN-1:0]   w_abs1;
    logic [XLEN-1:0]   w_abs2;
    logic [XLEN:0]     w_shift;
    logic [XLEN+1:0]   w_diff;
    logic [XLEN-1:0]   w_q_nx;
    logic [XLEN-1:0]   w_r_nx;
    logic [XLEN-1:0]   w_fin;

    assign w_f3  = inst_i[14:12];
    assign w_go  = arst_n && r_state == IDLE && !jump_ena_i &&
                   inst_i[6:0] == 7'b0110011 && inst_i[31:25] == 7'b0000001;
    assign w_sgn = !w_f3[0];
    assign w_ovf = w_sgn && reg1_r_data_i == {1'b1, {(XLEN-1){1'b0}}} && reg2_r_data_i == '1;

    // Extending to 2*XLEN makes a plain multiply equal the signed 33x33 product modulo 2^64
    assign w_ma   = {{XLEN{w_f3 != 3'b011 && reg1_r_data_i[XLEN-1]}}, reg1_r_data_i};
    assign w_mb   = {{XLEN{!w_f3[1] && reg2_r_data_i[XLEN-1]}}, reg2_r_data_i};
    assign w_prod = w_ma * w_mb;

    assign w_abs1 = (w_sgn && reg1_r_data_i[XLEN-1]) ? -reg1_r_data_i : reg1_r_data_i;
    assign w_abs2 = (w_sgn && reg2_r_data_i[XLEN-1]) ? -reg2_r_data_i : reg2_r_data_i;

    assign w_shift = {r_rem, r_quot[XLEN-1]};
    assign w_diff  = {1'b0, w_shift} - {2'b00, r_divisor};
    assign w_r_nx  = w_diff[XLEN+1] ? w_shift[XLEN-1:0] : w_diff[XLEN-1:0];
    assign w_q_nx  = {r_quot[XLEN-2:0], !w_diff[XLEN+1]};
    assign w_fin   = r_rem_sel ? (r_neg_r ? -w_r_nx : w_r_nx) : (r_neg_q ? -w_q_nx : w_q_nx);

    assign w_wb         = r_state == DONE && !jump_ena_i;
    assign hold_req_o   = w_go || (r_state == DIV_BUSY && !jump_ena_i);
    assign busy_o       = r_state != IDLE;
    assign wb_valid_o   = w_wb;
    assign reg_w_e_o    = w_wb && r_rd != 5'd0;
    assign reg_w_addr_o = w_wb ? r_rd : 5'd0;
    assign result_o     = w_wb ? r_result : '0;
    assign w_unused     = ^{inst_i[24:15], inst_i[11:7], w_diff[XLEN]};

    always_ff @(posedge clk_100MHz or negedge arst_n) begin
        if (!arst_n) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_rd      <= '0;
            r_rem_sel <= 1'b0;
            r_neg_q   <= 1'b0;
            r_neg_r   <= 1'b0;
            r_quot    <= '0;
            r_rem     <= '0;
            r_divisor <= '0;
            r_result  <= '0;
        end else begin
            case (r_state)
                IDLE: if (w_go) begin
                    r_rd      <= reg_w_addr_i;
                    r_rem_sel <= w_f3[1];
                    if (!w_f3[2]) begin
                        r_result <= (w_f3 == 3'b000) ? w_prod[XLEN-1:0] : w_prod[2*XLEN-1:XLEN];
                        r_state  <= DONE;
                    end else if (reg2_r_data_i == '0) begin
                        r_result <= w_f3[1] ? reg1_r_data_i : '1;
                        r_state  <= DONE;
                    end else if (w_ovf) begin
                        r_result <= w_f3[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
                        r_state  <= DONE;
                    end else begin
                        r_quot    <= w_abs1;
                        r_divisor <= w_abs2;
                        r_rem     <= '0;
                        r_cnt     <= '0;
                        r_neg_q   <= w_sgn && (reg1_r_data_i[XLEN-1] ^ reg2_r_data_i[XLEN-1]);
                        r_neg_r   <= w_sgn && reg1_r_data_i[XLEN-1];
                        r_state   <= DIV_BUSY;
                    end
                end
                DIV_BUSY: if (jump_ena_i) begin
                    r_state <= IDLE;
                end else begin
                    r_quot <= w_q_nx;
                    r_rem  <= w_r_nx;
                    r_cnt  <= r_cnt + CW'(1);
                    if (r_cnt == CW'(XLEN-1)) begin
                        r_result <= w_fin;
                        r_state  <= DONE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ex_muldiv.sv
// tb_ex_muldiv: table-driven directed vectors for ex_muldiv plus abort and mid-divide reset sequences.
module tb_ex_muldiv;
    logic        clk_100MHz = 1'b0;
    logic        arst_n = 1'b0;
    logic [31:0] inst_i = 32'h13;
    logic [31:0] reg1_r_data_i = '0;
    logic [31:0] reg2_r_data_i = '0;
    logic [4:0]  reg_w_addr_i = '0;
    logic        jump_ena_i = 1'b0;
    logic        hold_req_o, busy_o, wb_valid_o, reg_w_e_o;
    logic [4:0]  reg_w_addr_o;
    logic [31:0] result_o;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    vec_t vecs[18];

    ex_muldiv dut (
        .clk_100MHz   (clk_100MHz),
        .arst_n       (arst_n),
        .inst_i       (inst_i),
        .reg1_r_data_i(reg1_r_data_i),
        .reg2_r_data_i(reg2_r_data_i),
        .reg_w_addr_i (reg_w_addr_i),
        .jump_ena_i   (jump_ena_i),
        .hold_req_o   (hold_req_o),
        .busy_o       (busy_o),
        .wb_valid_o   (wb_valid_o),
        .reg_w_e_o    (reg_w_e_o),
        .reg_w_addr_o (reg_w_addr_o),
        .result_o     (result_o)
    );

    always #5 clk_100MHz = ~clk_100MHz;

    function automatic logic [31:0] enc(input logic [2:0] f3, input logic [4:0] rd);
        return {7'b0000001, 10'd0, f3, rd, 7'b0110011};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic flags_zero(input string name);
        chk({name, " result"}, result_o, 32'd0);
        chk({name, " flags"}, 32'({busy_o, hold_req_o, wb_valid_o, reg_w_e_o, reg_w_addr_o}), 32'd0);
    endtask

    // Instruction stays on the inputs until its writeback beat, like a held ID/EX register
    task automatic run(input vec_t v, input int idx);
        int n;
        int hc;
        @(posedge clk_100MHz);
        #1;
        inst_i = enc(v.f3, v.rd);
        reg1_r_data_i = v.a;
        reg2_r_data_i = v.b;
        reg_w_addr_i = v.rd;
        n = 0;
        hc = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk_100MHz);
            n++;
            if (wb_valid_o) break;
            if (hold_req_o) hc++;
        end
        chk($sformatf("v%0d wb cycle", idx), n, v.lat + 1);
        chk($sformatf("v%0d hold cycles", idx), hc, v.lat);
        chk($sformatf("v%0d result", idx), result_o, v.exp);
        chk($sformatf("v%0d hold at wb", idx), 32'(hold_req_o), 32'd0);
        chk($sformatf("v%0d reg_w_e", idx), 32'(reg_w_e_o), 32'(v.rd != 5'd0));
        chk($sformatf("v%0d reg_w_addr", idx), 32'(reg_w_addr_o), 32'(v.rd));
    endtask

    initial begin
        int wb_seen;
        vecs[0]  = '{3'd0, 32'd7,          32'hFFFFFFFD, 5'd5,  32'hFFFFFFEB, 1};
        vecs[1]  = '{3'd3, 32'hFFFFFFFF,   32'hFFFFFFFF, 5'd6,  32'hFFFFFFFE, 1};
        vecs[2]  = '{3'd1, 32'hFFFFFFFF,   32'hFFFFFFFF, 5'd7,  32'h00000000, 1};
        vecs[3]  = '{3'd2, 32'hFFFFFFFF,   32'hFFFFFFFF, 5'd8,  32'hFFFFFFFF, 1};
        vecs[4]  = '{3'd1, 32'h80000000,   32'h80000000, 5'd9,  32'h40000000, 1};
        vecs[5]  = '{3'd4, 32'hFFFFFFF9,   32'd2,        5'd10, 32'hFFFFFFFD, 33};
        vecs[6]  = '{3'd6, 32'hFFFFFFF9,   32'd2,        5'd11, 32'hFFFFFFFF, 33};
        vecs[7]  = '{3'd5, 32'd100,        32'd7,        5'd12, 32'd14,       33};
        vecs[8]  = '{3'd7, 32'd100,        32'd7,        5'd13, 32'd2,        33};
        vecs[9]  = '{3'd5, 32'd5,          32'd0,        5'd14, 32'hFFFFFFFF, 1};
        vecs[10] = '{3'd7, 32'd5,          32'd0,        5'd15, 32'd5,        1};
        vecs[11] = '{3'd4, 32'h80000000,   32'hFFFFFFFF, 5'd16, 32'h80000000, 1};
        vecs[12] = '{3'd6, 32'h80000000,   32'hFFFFFFFF, 5'd17, 32'h00000000, 1};
        vecs[13] = '{3'd4, 32'd9,          32'd3,        5'd0,  32'd3,        33};
        vecs[14] = '{3'd4, 32'd7,          32'hFFFFFFFD, 5'd18, 32'hFFFFFFFE, 33};
        vecs[15] = '{3'd6, 32'd7,          32'hFFFFFFFD, 5'd19, 32'd1,        33};
        vecs[16] = '{3'd5, 32'h80000000,   32'hFFFFFFFF, 5'd20, 32'h00000000, 33};
        vecs[17] = '{3'd4, 32'h80000000,   32'd2,        5'd21, 32'hC0000000, 33};

        #12;
        flags_zero("reset");
        @(negedge clk_100MHz);
        arst_n = 1'b1;
        @(negedge clk_100MHz);
        flags_zero("idle");

        for (int i = 0; i < 18; i++) run(vecs[i], i);
        @(posedge clk_100MHz);
        #1;
        inst_i = 32'h13;
        @(negedge clk_100MHz);
        flags_zero("after table");

        // Flush at DIV_BUSY cycle 10
        @(posedge clk_100MHz);
        #1;
        inst_i = enc(3'd5, 5'd3);
        reg1_r_data_i = 32'd100;
        reg2_r_data_i = 32'd7;
        reg_w_addr_i = 5'd3;
        @(posedge clk_100MHz);
        repeat (9) @(posedge clk_100MHz);
        #1;
        jump_ena_i = 1'b1;
        #1;
        chk("abort busy", 32'(busy_o), 32'd1);
        chk("abort hold", 32'(hold_req_o), 32'd0);
        chk("abort wb", 32'(wb_valid_o), 32'd0);
        @(posedge clk_100MHz);
        #1;
        jump_ena_i = 1'b0;
        inst_i = 32'h13;
        flags_zero("abort next");
        wb_seen = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk_100MHz);
            if (wb_valid_o) wb_seen++;
        end
        chk("abort no wb", wb_seen, 0);

        // Asynchronous reset at DIV_BUSY cycle 5
        @(posedge clk_100MHz);
        #1;
        inst_i = enc(3'd4, 5'd4);
        reg1_r_data_i = 32'd100;
        reg2_r_data_i = 32'd7;
        reg_w_addr_i = 5'd4;
        repeat (5) @(posedge clk_100MHz);
        #1;
        chk("pre-reset busy", 32'(busy_o), 32'd1);
        arst_n = 1'b0;
        #1;
        flags_zero("mid reset");
        inst_i = 32'h13;
        @(negedge clk_100MHz);
        arst_n = 1'b1;
        @(negedge clk_100MHz);
        flags_zero("post reset");
        run('{3'd4, 32'd8, 32'd2, 5'd9, 32'd4, 33}, 99);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
